fifo_256_unpack: RTL
====================

# fifo_256_unpack

Width-down converter on the read side of the 256-bit, 8-deep `simple_fifo` instance. It pops wide words from the FIFO and presents them as a stream of `OUT_WIDTH`-bit slices with a valid/ready handshake and a last-slice marker. It uses a one-word prefetch buffer so the output runs bubble-free at full rate while the FIFO has data.

## Interface
Parameters:
- `IN_WIDTH`, 256, FIFO word width; must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, 32, output slice width; `RATIO = IN_WIDTH/OUT_WIDTH` must be ≥ 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset, sampled on `clk`.
- `fifo_re` in→FIFO, out 1: FIFO pop request; combinational from registered state and `fifo_empty`.
- `fifo_dout` in `IN_WIDTH`: FIFO read data, valid the cycle after a pop.
- `fifo_empty` in 1: FIFO empty flag.
- `out_data` out `OUT_WIDTH`: current slice.
- `out_valid` out 1: slice valid.
- `out_last` out 1: current slice is the final slice of its wide word.
- `out_ready` in 1: downstream accepts the slice.
- `busy` out 1: any word held or in flight (`cur_valid | nxt_valid | pending`).

## Operation
- State registers:
  - `cur` (`IN_WIDTH`) with `cur_valid`, the word being emitted.
  - `idx` (`$clog2(RATIO)` bits), the slice index.
  - `nxt` (`IN_WIDTH`) with `nxt_valid`, the prefetch buffer.
  - `pending`, a pop issued last cycle whose data lands this cycle.
- Pop rule: `fifo_re = !fifo_empty && !pending && !nxt_valid`. At most one read is ever in flight.
- Capture (`pending == 1`), data goes to `cur` if `cur` is free at the end of this cycle, otherwise to `nxt`.
  - `cur` is free when `!cur_valid`, or when its last slice is accepted this cycle while `nxt` is empty.
- Output: `out_valid = cur_valid`. `out_data` = slice `idx` of `cur`. `out_last = cur_valid && idx == RATIO-1`.
- Handshake: a transfer occurs when `out_valid && out_ready`.
  - On a transfer with `idx < RATIO-1`: `idx` increments.
  - On a transfer with `idx == RATIO-1`: `idx` returns to 0, `cur` is reloaded from `nxt` if `nxt_valid` (clearing `nxt_valid`), else from the landing data if `pending`, else `cur_valid` clears.
- `out_data` and `out_last` hold stable while `out_valid && !out_ready`. `idx` never wraps without a transfer.
- Backpressure never loses data. With `out_ready` low indefinitely, the block holds `cur` plus `nxt` and issues no further pops.
- Reset:
  - `cur_valid`, `nxt_valid`, `pending` and `idx` go to 0.
  - `out_valid`, `out_last` and `busy` go to 0; `out_data` goes to 0 (`cur` cleared).
  - `fifo_re` is 0 during the reset cycle.
  - A pop in flight at reset is discarded. The FIFO shares `reset`, so its contents are discarded as well.

## Timing
- First-word latency:
  - `fifo_empty` low in cycle 0 gives `fifo_re` high in cycle 0.
  - `fifo_dout` is valid in cycle 1 and captured at the end of cycle 1.
  - `out_valid` is high in cycle 2.
- Sustained rate: with `out_ready` held high and the FIFO non-empty, one slice per cycle with no bubbles. The prefetch completes `RATIO-2` cycles before it is needed.
- `out_*` are registered; `fifo_re` is the only combinational output.
- Pop and last-slice transfer in the same cycle is legal. Capture and last-slice transfer in the same cycle loads `cur` directly, with no gap.

## Configuration
- `FIFO_256_UNPACK_MSB_FIRST_EN` undefined: slice 0 = `cur[OUT_WIDTH-1:0]` (LSB first).
- `FIFO_256_UNPACK_MSB_FIRST_EN` defined: slice 0 = `cur[IN_WIDTH-1:IN_WIDTH-OUT_WIDTH]` (MSB first).
- Handshake, timing and `out_last` are identical in both builds.

## Test plan
- Single word `0x...0000000700000006...00000000` with `out_ready` = 1:
  - `fifo_re` is high one cycle; `out_valid` rises 2 cycles later.
  - Output is `0,1,...,7` (LSB build) on 8 consecutive cycles, `out_last` on the 8th, then `busy` = 0.
- 8 words back-to-back with `out_ready` = 1: 64 slices on 64 consecutive cycles with no `out_valid` gap, and `out_last` every 8th slice.
- `out_ready` low for 20 cycles after slice 3 with the FIFO holding 5 words:
  - Exactly one extra pop occurs (`nxt` full), then `fifo_re` stays 0.
  - `out_data` holds slice 3.
  - When `out_ready` rises again, the stream resumes at slice 3 with no loss.
- Random `out_ready` (50 %) over 100 words: the output stream equals the input words sliced in order, checked by a scoreboard.
- Reset asserted one cycle after `fifo_re`: all outputs are 0 the next cycle, and the landing word never appears on `out_data`.
- MSB build (`FIFO_256_UNPACK_MSB_FIRST_EN` defined), same word as the first test: output is `7,6,...,0`.

Source files
------------

// File: rtl/fifo_256_unpack.sv
// Width-down converter: pops IN_WIDTH-bit words from a FIFO and streams them out as
// OUT_WIDTH-bit slices. Define FIFO_256_UNPACK_MSB_FIRST_EN to emit the top slice first.
module fifo_256_unpack #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 fifo_re,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_empty,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned Ratio = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IdxW  = $clog2(Ratio);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Ratio - 1);

  logic [IN_WIDTH-1:0] cur_q, cur_d;
  logic                cur_valid_q, cur_valid_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IN_WIDTH-1:0] nxt_q, nxt_d;
  logic                nxt_valid_q, nxt_valid_d;
  logic                pending_q, pending_d;

  logic xfer, last_xfer, cur_free;

  logic [OUT_WIDTH-1:0] slices [Ratio];

  for (genvar i = 0; i < Ratio; i++) begin : g_slice
`ifdef FIFO_256_UNPACK_MSB_FIRST_EN
    assign slices[i] = cur_q[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
`else
    assign slices[i] = cur_q[i*OUT_WIDTH +: OUT_WIDTH];
`endif
  end

  // One read in flight at most, and only when the prefetch buffer has room for it.
  assign fifo_re   = !reset && !fifo_empty && !pending_q && !nxt_valid_q;

  assign out_valid = cur_valid_q;
  assign out_data  = slices[idx_q];
  assign out_last  = cur_valid_q && (idx_q == IdxLast);
  assign busy      = cur_valid_q || nxt_valid_q || pending_q;

  assign xfer      = cur_valid_q && out_ready;
  assign last_xfer = xfer && (idx_q == IdxLast);
  assign cur_free  = !cur_valid_q || (last_xfer && !nxt_valid_q);

  always_comb begin
    cur_d       = cur_q;
    cur_valid_d = cur_valid_q;
    idx_d       = idx_q;
    nxt_d       = nxt_q;
    nxt_valid_d = nxt_valid_q;
    pending_d   = fifo_re;

    if (xfer) begin
      if (idx_q == IdxLast) begin
        idx_d = '0;
        if (nxt_valid_q) begin
          cur_d       = nxt_q;
          nxt_valid_d = 1'b0;
        end else if (!pending_q) begin
          cur_valid_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end

    // Landing data goes straight to cur when it frees up this cycle, so no gap appears.
    if (pending_q) begin
      if (cur_free) begin
        cur_d       = fifo_dout;
        cur_valid_d = 1'b1;
      end else begin
        nxt_d       = fifo_dout;
        nxt_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q       <= '0;
      cur_valid_q <= 1'b0;
      idx_q       <= '0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      cur_valid_q <= cur_valid_d;
      idx_q       <= idx_d;
      nxt_q       <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      pending_q   <= pending_d;
    end
  end

endmodule
